pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Second-generation pipeline hazard and redirect controller for the RV32I pipeline.
- Generalises operand forwarding to FWD_STAGES producer stages and replaces the fixed load-use check with per-stage data-ready flags.
- Adds a register scoreboard for variable-latency writebacks (multicycle MUL/DIV, long memory loads).
- Adds a sequenced fence.i handshake with the icache.
- Sits beside IDU/EXU; drives EXU operands, the IF/ID stall, the EX flush and the next-PC redirect.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count (16 for RV32E); RW = $clog2(NREG)
FWD_STAGES, 3, forwarding sources; index 0 = youngest (EX), FWD_STAGES-1 = oldest (WB)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1, id_rs2  in  RW  source register indices
id_rs1_value, id_rs2_value  in  XLEN  register-file read data
fwd_valid, fwd_wen, fwd_ready  in  FWD_STAGES  per-stage valid, writes-rd, result-available (0 = load in flight)
fwd_rd  in  FWD_STAGES*RW  per-stage destination register
fwd_data  in  FWD_STAGES*XLEN  per-stage result
lu_issue, lu_done  in  1  long-latency op issued / completed
lu_issue_rd, lu_done_rd  in  RW  rd of the issued / completed op
redirect_req  in  1  taken branch or jump resolved in EX
redirect_pc  in  XLEN  redirect target
trap_req  in  1  ecall or mret
trap_pc  in  XLEN  mtvec or mepc target
fence_i_req  in  1  fence.i in EX
fence_pc  in  XLEN  fence.i PC + 4
icache_clr_done  in  1  icache invalidation finished
ex_rs1_in, ex_rs2_in  out  XLEN  forwarded operands
id_stall  out  1  hold IF/ID
ex_flush  out  1  insert a bubble into EX
dnpc  out  XLEN  next PC
dnpc_flag  out  1  redirect valid
icache_clr  out  1  icache invalidate request
sb_busy  out  1  scoreboard non-empty

Behaviour:
Reset values:
- Asynchronous reset, effective immediately, from any state including mid-fence.
- Returns to IDLE, clears the scoreboard, drives every output to 0. icache_clr drops without waiting for icache_clr_done.

Forwarding (combinational):
- For each source, take the lowest-index stage i with fwd_valid[i] & fwd_wen[i] & fwd_rd[i]==rs & rs!=0.
- If i exists and fwd_ready[i]=1: operand = fwd_data[i].
- If i exists and fwd_ready[i]=0: raise a data stall; operand is don't-care.
- If no stage matches: operand = register-file value.
- x0 always reads the register-file value and never stalls.

Scoreboard:
- NREG pending bits, bit 0 hardwired to 0.
- lu_issue sets bit[lu_issue_rd] at the clock edge; lu_done clears bit[lu_done_rd].
- Same rd issued and completed in the same cycle: bit stays set.
- rs pending with no ready forward match gives a data stall. A ready forward match overrides a pending bit.
- sb_busy = OR of all pending bits, registered view.

Stall and flush:
- id_stall = id_valid & data stall, OR FSM not in IDLE.
- ex_flush = id_stall | dnpc_flag.

Redirect FSM, states IDLE, DRAIN, CLR, RESUME:
- IDLE, priority trap_req > redirect_req > fence_i_req.
  - trap_req: dnpc = trap_pc, dnpc_flag = 1, same cycle, combinational.
  - redirect_req: dnpc = redirect_pc, dnpc_flag = 1, same cycle, combinational.
  - fence_i_req: latch fence_pc, go to DRAIN.
- DRAIN: wait until sb_busy = 0 (a lu_done clearing the last bit counts this cycle), then go to CLR.
- CLR: icache_clr = 1 held until icache_clr_done, then go to RESUME. A done that arrives in the same cycle as entry is honoured.
- RESUME: dnpc = latched fence_pc, dnpc_flag = 1 for exactly one cycle, then go to IDLE.
- trap_req and redirect_req are ignored outside IDLE. EX carries only bubbles there; the bench asserts this.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0], perf_flush_events[31:0] and perf_fence_cycles[31:0].
  - Counters increment on id_stall, on dnpc_flag, and on non-IDLE cycles respectively.
  - They wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is unchanged.

Test Plan:
- Forward priority: stages 0 and 2 both write x5, rs1 = 5, fwd_data 0xAAAA0000 / 0x0000BBBB -> ex_rs1_in = 0xAAAA0000, id_stall = 0.
- Load-use: stage 0 writes x7 with fwd_ready = 0, rs2 = 7 -> id_stall = 1 and ex_flush = 1; next cycle fwd_ready[1] = 1 with data 0x12345678 -> stall drops, ex_rs2_in = 0x12345678.
- Scoreboard: lu_issue rd = 9, then rs1 = 9 for 6 cycles with no forward match -> id_stall = 1 for 6 cycles; lu_done rd = 9 -> stall clears next cycle. Same-cycle issue and done of rd = 3 -> sb_busy stays 1.
- Fence sequence: fence_i_req with fence_pc = 0x80000104 while x4 is pending -> DRAIN until lu_done, CLR with icache_clr = 1 until icache_clr_done after 3 cycles, then one cycle dnpc_flag = 1 with dnpc = 0x80000104.
- Redirect priority: trap_req, redirect_req and fence_i_req asserted together in IDLE -> dnpc = trap_pc, state stays IDLE.
- x0 and reset: rs1 = 0 with stage 0 writing x0 -> register-file value, no stall. Assert reset during CLR -> icache_clr = 0 immediately, sb_busy = 0, state IDLE.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID operands, per-stage forwarding, long-latency tracking, redirect and icache handshakes.
// master = pipeline side driving requests, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FWD_STAGES = 3
);
    localparam int RW = $clog2(NREG);

    logic                         id_valid;
    logic [RW-1:0]                id_rs1;
    logic [RW-1:0]                id_rs2;
    logic [XLEN-1:0]              id_rs1_value;
    logic [XLEN-1:0]              id_rs2_value;
    logic [FWD_STAGES-1:0]        fwd_valid;
    logic [FWD_STAGES-1:0]        fwd_wen;
    logic [FWD_STAGES-1:0]        fwd_ready;
    logic [FWD_STAGES*RW-1:0]     fwd_rd;
    logic [FWD_STAGES*XLEN-1:0]   fwd_data;
    logic                         lu_issue;
    logic                         lu_done;
    logic [RW-1:0]                lu_issue_rd;
    logic [RW-1:0]                lu_done_rd;
    logic                         redirect_req;
    logic [XLEN-1:0]              redirect_pc;
    logic                         trap_req;
    logic [XLEN-1:0]              trap_pc;
    logic                         fence_i_req;
    logic [XLEN-1:0]              fence_pc;
    logic                         icache_clr_done;

    logic [XLEN-1:0]              ex_rs1_in;
    logic [XLEN-1:0]              ex_rs2_in;
    logic                         id_stall;
    logic                         ex_flush;
    logic [XLEN-1:0]              dnpc;
    logic                         dnpc_flag;
    logic                         icache_clr;
    logic                         sb_busy;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_value, id_rs2_value,
               fwd_valid, fwd_wen, fwd_ready, fwd_rd, fwd_data,
               lu_issue, lu_done, lu_issue_rd, lu_done_rd,
               redirect_req, redirect_pc, trap_req, trap_pc,
               fence_i_req, fence_pc, icache_clr_done,
        input  ex_rs1_in, ex_rs2_in, id_stall, ex_flush,
               dnpc, dnpc_flag, icache_clr, sb_busy
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_value, id_rs2_value,
               fwd_valid, fwd_wen, fwd_ready, fwd_rd, fwd_data,
               lu_issue, lu_done, lu_issue_rd, lu_done_rd,
               redirect_req, redirect_pc, trap_req, trap_pc,
               fence_i_req, fence_pc, icache_clr_done,
        output ex_rs1_in, ex_rs2_in, id_stall, ex_flush,
               dnpc, dnpc_flag, icache_clr, sb_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RV32I hazard/redirect controller: combinational forwarding, stall and trap/branch redirect; fence.i takes DRAIN->CLR->RESUME.
// Stalls IF/ID while a source is not ready or a fence is sequencing; HAZARD_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FWD_STAGES = 3
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_events,
    output logic [31:0]        perf_fence_cycles
`endif
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        CLR    = 2'd2,
        RESUME = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   fence_pc_q;
    logic              icache_clr_q;
    logic [NREG-1:0]   pending;
    logic              sb_busy_q;

    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   sb_next;

    logic              hit1, rdy1, hit2, rdy2;
    logic [XLEN-1:0]   fd1, fd2;
    logic              stall1, stall2, data_stall;
    logic [XLEN-1:0]   op1, op2;
    logic              stall_c, flush_c, flag_c;
    logic [XLEN-1:0]   pc_c;

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        hit1 = 1'b0;
        rdy1 = 1'b0;
        fd1  = '0;
        hit2 = 1'b0;
        rdy2 = 1'b0;
        fd2  = '0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (bus.fwd_valid[i] && bus.fwd_wen[i] &&
                bus.fwd_rd[i*RW +: RW] == bus.id_rs1 && bus.id_rs1 != '0) begin
                hit1 = 1'b1;
                rdy1 = bus.fwd_ready[i];
                fd1  = bus.fwd_data[i*XLEN +: XLEN];
            end
            if (bus.fwd_valid[i] && bus.fwd_wen[i] &&
                bus.fwd_rd[i*RW +: RW] == bus.id_rs2 && bus.id_rs2 != '0) begin
                hit2 = 1'b1;
                rdy2 = bus.fwd_ready[i];
                fd2  = bus.fwd_data[i*XLEN +: XLEN];
            end
        end
    end

    // A ready forward beats a pending scoreboard bit; x0 is never pending.
    always_comb begin
        stall1     = hit1 ? ~rdy1 : pending[bus.id_rs1];
        stall2     = hit2 ? ~rdy2 : pending[bus.id_rs2];
        data_stall = stall1 | stall2;
        op1        = hit1 ? fd1 : bus.id_rs1_value;
        op2        = hit2 ? fd2 : bus.id_rs2_value;
    end

    always_comb begin
        set_mask = bus.lu_issue ? (NREG'(1) << bus.lu_issue_rd) : '0;
        clr_mask = bus.lu_done  ? (NREG'(1) << bus.lu_done_rd)  : '0;
        sb_next  = (pending & ~clr_mask) | set_mask;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            sb_busy_q <= 1'b0;
        end else begin
            pending   <= sb_next;
            sb_busy_q <= |sb_next;
        end
    end

    always_comb begin
        flag_c = 1'b0;
        pc_c   = '0;
        case (state)
            IDLE: begin
                if (bus.trap_req) begin
                    flag_c = 1'b1;
                    pc_c   = bus.trap_pc;
                end else if (bus.redirect_req) begin
                    flag_c = 1'b1;
                    pc_c   = bus.redirect_pc;
                end
            end
            RESUME: begin
                flag_c = 1'b1;
                pc_c   = fence_pc_q;
            end
            default: ;
        endcase
        stall_c = (bus.id_valid & data_stall) | (state != IDLE);
        flush_c = stall_c | flag_c;
    end

    // DRAIN looks at next-cycle occupancy so a completing op releases it immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fence_pc_q   <= '0;
            icache_clr_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.trap_req && !bus.redirect_req && bus.fence_i_req) begin
                        fence_pc_q <= bus.fence_pc;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (sb_next == '0) begin
                        icache_clr_q <= 1'b1;
                        state        <= CLR;
                    end
                end
                CLR: begin
                    if (bus.icache_clr_done) begin
                        icache_clr_q <= 1'b0;
                        state        <= RESUME;
                    end
                end
                RESUME: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign bus.ex_rs1_in  = reset ? '0   : op1;
    assign bus.ex_rs2_in  = reset ? '0   : op2;
    assign bus.id_stall   = reset ? 1'b0 : stall_c;
    assign bus.ex_flush   = reset ? 1'b0 : flush_c;
    assign bus.dnpc       = reset ? '0   : pc_c;
    assign bus.dnpc_flag  = reset ? 1'b0 : flag_c;
    assign bus.icache_clr = icache_clr_q;
    assign bus.sb_busy    = sb_busy_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
            perf_fence_cycles <= '0;
        end else begin
            if (stall_c)         perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flag_c)          perf_flush_events <= perf_flush_events + 32'd1;
            if (state != IDLE)   perf_fence_cycles <= perf_fence_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, scoreboard, fence.i sequence, redirect priority, reset.
module tb_pipe_hazard_ctrl;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int FS   = 3;
    localparam int RW   = 5;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FS)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_events, perf_fence_cycles;
`endif

    pipe_hazard_ctrl #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events),
        .perf_fence_cycles (perf_fence_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_stage(input int i, input logic v, input logic w, input logic r,
                             input logic [RW-1:0] rd, input logic [31:0] d);
        bus.fwd_valid[i]           = v;
        bus.fwd_wen[i]             = w;
        bus.fwd_ready[i]           = r;
        bus.fwd_rd[i*RW +: RW]     = rd;
        bus.fwd_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_all();
        bus.id_valid        = 1'b0;
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_rs1_value    = '0;
        bus.id_rs2_value    = '0;
        bus.fwd_valid       = '0;
        bus.fwd_wen         = '0;
        bus.fwd_ready       = '0;
        bus.fwd_rd          = '0;
        bus.fwd_data        = '0;
        bus.lu_issue        = 1'b0;
        bus.lu_done         = 1'b0;
        bus.lu_issue_rd     = '0;
        bus.lu_done_rd      = '0;
        bus.redirect_req    = 1'b0;
        bus.redirect_pc     = '0;
        bus.trap_req        = 1'b0;
        bus.trap_pc         = '0;
        bus.fence_i_req     = 1'b0;
        bus.fence_pc        = '0;
        bus.icache_clr_done = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        clear_all();
        #2;
        reset = 1'b1;
        bus.id_valid     = 1'b1;
        bus.id_rs1_value = 32'h0000_0055;
        settle();
        check("rst_ex_rs1", bus.ex_rs1_in, 32'h0);
        check("rst_stall", {31'b0, bus.id_stall}, 32'h0);
        check("rst_flush", {31'b0, bus.ex_flush}, 32'h0);
        check("rst_dnpc_flag", {31'b0, bus.dnpc_flag}, 32'h0);
        check("rst_dnpc", bus.dnpc, 32'h0);
        check("rst_icache_clr", {31'b0, bus.icache_clr}, 32'h0);
        check("rst_sb_busy", {31'b0, bus.sb_busy}, 32'h0);
        tick();
        reset = 1'b0;
        clear_all();
        tick();

        // Forward priority: stage 0 beats stage 2.
        bus.id_valid = 1'b1;
        bus.id_rs1 = 5'd5;
        bus.id_rs2 = 5'd0;
        bus.id_rs2_value = 32'h0000_0022;
        set_stage(0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hAAAA_0000);
        set_stage(2, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_BBBB);
        settle();
        check("fwd_prio_rs1", bus.ex_rs1_in, 32'hAAAA_0000);
        check("fwd_prio_rs2_rf", bus.ex_rs2_in, 32'h0000_0022);
        check("fwd_prio_stall", {31'b0, bus.id_stall}, 32'h0);
        check("fwd_prio_flush", {31'b0, bus.ex_flush}, 32'h0);
        tick();

        // Load-use stall then release from stage 1.
        clear_all();
        bus.id_valid = 1'b1;
        bus.id_rs2 = 5'd7;
        set_stage(0, 1'b1, 1'b1, 1'b0, 5'd7, 32'hDEAD_DEAD);
        settle();
        check("lu_stall", {31'b0, bus.id_stall}, 32'h1);
        check("lu_flush", {31'b0, bus.ex_flush}, 32'h1);
        tick();
        set_stage(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        set_stage(1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1234_5678);
        settle();
        check("lu_release_stall", {31'b0, bus.id_stall}, 32'h0);
        check("lu_release_rs2", bus.ex_rs2_in, 32'h1234_5678);
        tick();

        // Scoreboard stall on x9.
        clear_all();
        bus.id_valid = 1'b1;
        bus.lu_issue = 1'b1;
        bus.lu_issue_rd = 5'd9;
        tick();
        bus.lu_issue = 1'b0;
        bus.id_rs1 = 5'd9;
        bus.id_rs1_value = 32'h0000_0077;
        check("sb_busy_set", {31'b0, bus.sb_busy}, 32'h1);
        for (int c = 0; c < 6; c++) begin
            settle();
            check("sb_stall", {31'b0, bus.id_stall}, 32'h1);
            tick();
        end
        set_stage(2, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0099);
        settle();
        check("sb_fwd_override_stall", {31'b0, bus.id_stall}, 32'h0);
        check("sb_fwd_override_rs1", bus.ex_rs1_in, 32'h0000_0099);
        set_stage(2, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        bus.lu_done = 1'b1;
        bus.lu_done_rd = 5'd9;
        settle();
        check("sb_done_cycle_stall", {31'b0, bus.id_stall}, 32'h1);
        tick();
        bus.lu_done = 1'b0;
        settle();
        check("sb_cleared_stall", {31'b0, bus.id_stall}, 32'h0);
        check("sb_cleared_rs1", bus.ex_rs1_in, 32'h0000_0077);
        check("sb_cleared_busy", {31'b0, bus.sb_busy}, 32'h0);

        // Same-cycle issue and completion of x3 keeps the bit set.
        clear_all();
        bus.lu_issue = 1'b1;
        bus.lu_issue_rd = 5'd3;
        bus.lu_done = 1'b1;
        bus.lu_done_rd = 5'd3;
        tick();
        clear_all();
        check("sb_same_cycle_busy", {31'b0, bus.sb_busy}, 32'h1);
        bus.lu_done = 1'b1;
        bus.lu_done_rd = 5'd3;
        tick();
        bus.lu_done = 1'b0;
        check("sb_x3_done_busy", {31'b0, bus.sb_busy}, 32'h0);

        // fence.i with x4 pending.
        bus.lu_issue = 1'b1;
        bus.lu_issue_rd = 5'd4;
        tick();
        bus.lu_issue = 1'b0;
        bus.fence_i_req = 1'b1;
        bus.fence_pc = 32'h8000_0104;
        settle();
        check("fence_idle_flag", {31'b0, bus.dnpc_flag}, 32'h0);
        check("fence_idle_stall", {31'b0, bus.id_stall}, 32'h0);
        tick();
        bus.fence_i_req = 1'b0;
        bus.fence_pc = 32'h0;
        bus.redirect_req = 1'b1;
        bus.redirect_pc = 32'h0000_DEAD;
        settle();
        check("drain_stall", {31'b0, bus.id_stall}, 32'h1);
        check("drain_flush", {31'b0, bus.ex_flush}, 32'h1);
        check("drain_redirect_ignored", {31'b0, bus.dnpc_flag}, 32'h0);
        check("drain_no_clr", {31'b0, bus.icache_clr}, 32'h0);
        tick();
        bus.redirect_req = 1'b0;
        check("drain_wait_clr", {31'b0, bus.icache_clr}, 32'h0);
        bus.lu_done = 1'b1;
        bus.lu_done_rd = 5'd4;
        tick();
        bus.lu_done = 1'b0;
        check("clr_c1", {31'b0, bus.icache_clr}, 32'h1);
        check("clr_sb_empty", {31'b0, bus.sb_busy}, 32'h0);
        tick();
        check("clr_c2", {31'b0, bus.icache_clr}, 32'h1);
        tick();
        bus.icache_clr_done = 1'b1;
        check("clr_c3", {31'b0, bus.icache_clr}, 32'h1);
        tick();
        bus.icache_clr_done = 1'b0;
        settle();
        check("resume_flag", {31'b0, bus.dnpc_flag}, 32'h1);
        check("resume_dnpc", bus.dnpc, 32'h8000_0104);
        check("resume_clr_low", {31'b0, bus.icache_clr}, 32'h0);
        check("resume_stall", {31'b0, bus.id_stall}, 32'h1);
        tick();
        check("post_fence_flag", {31'b0, bus.dnpc_flag}, 32'h0);
        check("post_fence_idle", {31'b0, bus.id_stall}, 32'h0);

        // Redirect priority: trap over branch over fence.
        bus.trap_req = 1'b1;
        bus.trap_pc = 32'h0000_0100;
        bus.redirect_req = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        bus.fence_i_req = 1'b1;
        bus.fence_pc = 32'h0000_0300;
        settle();
        check("prio_dnpc", bus.dnpc, 32'h0000_0100);
        check("prio_flag", {31'b0, bus.dnpc_flag}, 32'h1);
        check("prio_flush", {31'b0, bus.ex_flush}, 32'h1);
        tick();
        clear_all();
        settle();
        check("prio_stays_idle", {31'b0, bus.id_stall}, 32'h0);
        bus.redirect_req = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        settle();
        check("redirect_dnpc", bus.dnpc, 32'h0000_0200);
        tick();
        clear_all();

        // x0 never forwards or stalls.
        bus.id_valid = 1'b1;
        bus.id_rs1 = 5'd0;
        bus.id_rs1_value = 32'h0000_1234;
        set_stage(0, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        settle();
        check("x0_rs1", bus.ex_rs1_in, 32'h0000_1234);
        check("x0_stall", {31'b0, bus.id_stall}, 32'h0);
        tick();

        // Reset in the middle of CLR.
        clear_all();
        bus.fence_i_req = 1'b1;
        bus.fence_pc = 32'h0000_4000;
        tick();
        bus.fence_i_req = 1'b0;
        tick();
        check("pre_rst_clr", {31'b0, bus.icache_clr}, 32'h1);
        bus.lu_issue = 1'b1;
        bus.lu_issue_rd = 5'd6;
        tick();
        bus.lu_issue = 1'b0;
        check("pre_rst_busy", {31'b0, bus.sb_busy}, 32'h1);
        #2;
        reset = 1'b1;
        settle();
        check("rst_mid_clr", {31'b0, bus.icache_clr}, 32'h0);
        check("rst_mid_busy", {31'b0, bus.sb_busy}, 32'h0);
        check("rst_mid_stall", {31'b0, bus.id_stall}, 32'h0);
        tick();
        reset = 1'b0;
        settle();
        check("rst_release_idle", {31'b0, bus.id_stall}, 32'h0);
        tick();
        check("rst_idle_after_clk", {31'b0, bus.id_stall}, 32'h0);
        check("rst_no_clr_after_clk", {31'b0, bus.icache_clr}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
